ap_ctrl_hs_driver: RTL and testbench

AP_CTRL_HS_DRIVER -- requirements
Module: ap_ctrl_hs_driver

---
 rtl/ap_ctrl_hs_driver.sv | 155 +++++++++++++++
 tb/tb_ap_ctrl_hs_driver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ap_ctrl_hs_driver.sv
// Drives an HLS block's ap_ctrl_hs handshake for a configured number of serial
// transactions, with per-transaction latency statistics and an optional timeout.
module ap_ctrl_hs_driver #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_go,
  input  logic [CNT_W-1:0] cfg_num_txn,
  input  logic [7:0]       cfg_gap,
  input  logic [CNT_W-1:0] cfg_timeout,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             busy,
  output logic             finish,
  output logic             timeout_err,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] last_lat,
  output logic [CNT_W-1:0] max_lat
);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_DONE, GAP, FINISH, ERROR
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] num_txn_q;
  logic [CNT_W-1:0] timeout_q;
  logic [7:0]       gap_q;
  logic [7:0]       gap_cnt;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic [CNT_W-1:0] done_inc;
  logic             in_txn;
  logic             complete;
  logic             to_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  // lat_cnt/to_cnt already hold the count for the current cycle (1 in the first START cycle)
  assign in_txn   = (state == START) || (state == WAIT_DONE);
  assign complete = ((state == START) && ap_ready && ap_done) ||
                    ((state == WAIT_DONE) && ap_done);
  assign to_hit   = in_txn && (timeout_q != '0) && (to_cnt == timeout_q);
  assign done_inc = done_cnt + ONE;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ap_start    <= 1'b0;
      busy        <= 1'b0;
      finish      <= 1'b0;
      timeout_err <= 1'b0;
      issued_cnt  <= '0;
      done_cnt    <= '0;
      last_lat    <= '0;
      max_lat     <= '0;
      lat_cnt     <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      num_txn_q   <= '0;
      timeout_q   <= '0;
      gap_q       <= '0;
    end else begin
      case (state)
        IDLE, FINISH, ERROR: begin
          if (cfg_go) begin
            num_txn_q   <= cfg_num_txn;
            timeout_q   <= cfg_timeout;
            gap_q       <= cfg_gap;
            issued_cnt  <= '0;
            done_cnt    <= '0;
            last_lat    <= '0;
            max_lat     <= '0;
            timeout_err <= 1'b0;
            lat_cnt     <= ONE;
            to_cnt      <= ONE;
            if (cfg_num_txn == '0) begin
              state    <= FINISH;
              finish   <= 1'b1;
              busy     <= 1'b0;
              ap_start <= 1'b0;
            end else begin
              state    <= START;
              finish   <= 1'b0;
              busy     <= 1'b1;
              ap_start <= 1'b1;
            end
          end
        end

        START, WAIT_DONE: begin
          if ((state == START) && ap_ready) issued_cnt <= issued_cnt + ONE;
          if (complete) begin
            done_cnt <= done_inc;
            last_lat <= lat_cnt;
            max_lat  <= (lat_cnt > max_lat) ? lat_cnt : max_lat;
            if (done_inc == num_txn_q) begin
              state    <= FINISH;
              ap_start <= 1'b0;
              busy     <= 1'b0;
              finish   <= 1'b1;
            end else if (gap_q == 8'd0) begin
              state    <= START;
              ap_start <= 1'b1;
              lat_cnt  <= ONE;
              to_cnt   <= ONE;
            end else begin
              state    <= GAP;
              ap_start <= 1'b0;
              gap_cnt  <= gap_q;
            end
          end else if (to_hit) begin
            state       <= ERROR;
            ap_start    <= 1'b0;
            busy        <= 1'b0;
            finish      <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            lat_cnt <= sat_inc(lat_cnt);
            to_cnt  <= to_cnt + ONE;
            if ((state == START) && ap_ready) begin
              state    <= WAIT_DONE;
              ap_start <= 1'b0;
            end
          end
        end

        GAP: begin
          if (gap_cnt == 8'd1) begin
            state    <= START;
            ap_start <= 1'b1;
            lat_cnt  <= ONE;
            to_cnt   <= ONE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        default: begin
          state    <= IDLE;
          ap_start <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ap_ctrl_hs_driver.sv
// Bench for ap_ctrl_hs_driver: acts as the HLS responder and scores latencies
// through a queue of expected values pushed as each ap_done is driven.
module tb_ap_ctrl_hs_driver;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             cfg_go;
  logic [CNT_W-1:0] cfg_num_txn;
  logic [7:0]       cfg_gap;
  logic [CNT_W-1:0] cfg_timeout;
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             busy;
  logic             finish;
  logic             timeout_err;
  logic [CNT_W-1:0] issued_cnt;
  logic [CNT_W-1:0] done_cnt;
  logic [CNT_W-1:0] last_lat;
  logic [CNT_W-1:0] max_lat;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  ap_ctrl_hs_driver #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .cfg_go(cfg_go), .cfg_num_txn(cfg_num_txn),
    .cfg_gap(cfg_gap), .cfg_timeout(cfg_timeout), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .busy(busy), .finish(finish),
    .timeout_err(timeout_err), .issued_cnt(issued_cnt), .done_cnt(done_cnt),
    .last_lat(last_lat), .max_lat(max_lat)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic go(input int n, input int g, input int t);
    @(negedge clock);
    cfg_num_txn = CNT_W'(n);
    cfg_gap     = 8'(g);
    cfg_timeout = CNT_W'(t);
    cfg_go      = 1'b1;
    @(negedge clock);
    cfg_go      = 1'b0;
  endtask

  // rd: cycles before ap_ready, dd: cycles before ap_done (latency = dd+1)
  task automatic serve(input int rd, input int dd, input bit check_gap,
                       input int exp_gap, input int go_at);
    int idle = 0;
    int lat;
    while (!ap_start && idle < 300) begin
      @(negedge clock);
      idle++;
    end
    if (!ap_start) begin
      chk("start_wait", 0, 1);
      return;
    end
    if (check_gap) chk("gap_len", idle, exp_gap);
    for (int c = 1; c <= dd + 1; c++) begin
      chk("start_hold", int'(ap_start), int'(c <= rd + 1));
      ap_ready = (c == rd + 1);
      ap_done  = (c == dd + 1);
      if (c == go_at) begin
        cfg_go      = 1'b1;
        cfg_num_txn = CNT_W'(1);
      end else begin
        cfg_go = 1'b0;
      end
      if (ap_done) exp_q.push_back(dd + 1);
      @(negedge clock);
    end
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    cfg_go   = 1'b0;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      lat = exp_q.pop_front();
      chk("last_lat", int'(last_lat), lat);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    cfg_go = 1'b0; cfg_num_txn = '0; cfg_gap = '0; cfg_timeout = '0;
    ap_ready = 1'b0; ap_done = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    chk("rst_ap_start", int'(ap_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_finish", int'(finish), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    chk("rst_counts", int'(issued_cnt) + int'(done_cnt), 0);
    chk("rst_lats", int'(last_lat) + int'(max_lat), 0);

    // three transactions, ready after 1 cycle, done 4 cycles after start, gap 2
    go(3, 2, 0);
    chk("run_busy", int'(busy), 1);
    serve(1, 4, 1'b0, 0, 0);
    chk("done_cnt_1", int'(done_cnt), 1);
    serve(1, 4, 1'b1, 2, 0);
    serve(1, 4, 1'b1, 2, 0);
    chk("r1_finish", int'(finish), 1);
    chk("r1_busy", int'(busy), 0);
    chk("r1_ap_start", int'(ap_start), 0);
    chk("r1_issued", int'(issued_cnt), 3);
    chk("r1_done", int'(done_cnt), 3);
    chk("r1_max_lat", int'(max_lat), 5);

    // ready and done in the very first start cycle
    go(1, 0, 0);
    serve(0, 0, 1'b0, 0, 0);
    chk("r2_ap_start", int'(ap_start), 0);
    chk("r2_finish", int'(finish), 1);
    chk("r2_max_lat", int'(max_lat), 1);

    // second transaction never completes: timeout after 10 cycles
    go(2, 1, 10);
    serve(0, 2, 1'b0, 0, 0);
    n = 0;
    while (!ap_start && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("r3_gap", n, 1);
    ap_ready = 1'b1;
    @(negedge clock);
    ap_ready = 1'b0;
    n = 1;
    while (!finish && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("r3_to_cycles", n, 10);
    chk("r3_timeout_err", int'(timeout_err), 1);
    chk("r3_done", int'(done_cnt), 1);
    chk("r3_issued", int'(issued_cnt), 2);
    chk("r3_ap_start", int'(ap_start), 0);
    chk("r3_busy", int'(busy), 0);

    // zero-length run
    go(0, 0, 0);
    chk("r4_finish", int'(finish), 1);
    chk("r4_timeout_err", int'(timeout_err), 0);
    chk("r4_busy", int'(busy), 0);
    chk("r4_issued", int'(issued_cnt), 0);
    for (int i = 0; i < 3; i++) begin
      chk("r4_ap_start", int'(ap_start), 0);
      @(negedge clock);
    end

    // reset while waiting for done, then a stray ap_done
    go(1, 0, 0);
    chk("r5_ap_start", int'(ap_start), 1);
    ap_ready = 1'b1;
    @(negedge clock);
    ap_ready = 1'b0;
    chk("r5_wait_busy", int'(busy), 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("r5_rst_ap_start", int'(ap_start), 0);
    chk("r5_rst_busy", int'(busy), 0);
    chk("r5_rst_issued", int'(issued_cnt), 0);
    ap_done = 1'b1;
    @(negedge clock);
    ap_done = 1'b0;
    @(negedge clock);
    chk("r5_stray_done_cnt", int'(done_cnt), 0);
    chk("r5_stray_last_lat", int'(last_lat), 0);
    chk("r5_stray_max_lat", int'(max_lat), 0);
    chk("r5_stray_flags", int'(finish) + int'(timeout_err) + int'(busy) + int'(ap_start), 0);

    // extra cfg_go while busy must not disturb the run; latencies 7, 3, 9
    go(3, 1, 0);
    serve(0, 6, 1'b0, 0, 2);
    serve(1, 2, 1'b1, 1, 0);
    chk("r6_max_mid", int'(max_lat), 7);
    serve(0, 8, 1'b1, 1, 0);
    chk("r6_finish", int'(finish), 1);
    chk("r6_issued", int'(issued_cnt), 3);
    chk("r6_done", int'(done_cnt), 3);
    chk("r6_max_lat", int'(max_lat), 9);
    chk("r6_last_lat", int'(last_lat), 9);
    chk("sb_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
